// File: rtl/voice_mixer.sv
// voice_mixer: snapshots NVOICES signed voice samples and unsigned volumes on
// a sample strobe, then accumulates the volume-weighted sum one voice per
// cycle through a single multiplier. The sum is scaled down by 2^VOLBITS with
// floor rounding, saturated to BITDEPTH and presented with a one-cycle valid.
module voice_mixer #(
    parameter int NVOICES  = 4,
    parameter int BITDEPTH = 14,
    parameter int VOLBITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_strobe,
    input  logic [NVOICES*BITDEPTH-1:0]  voices_in,
    input  logic [NVOICES*VOLBITS-1:0]   volumes,
    input  logic                         overrun_clr,
    output logic [BITDEPTH-1:0]          mix_out,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDXW  = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int PRODW = BITDEPTH + VOLBITS + 1;
    localparam int ACCW  = PRODW + $clog2(NVOICES);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic signed [BITDEPTH-1:0] snap_voice_q [NVOICES];
    logic signed [BITDEPTH-1:0] snap_voice_d [NVOICES];
    logic [VOLBITS-1:0]         snap_vol_q   [NVOICES];
    logic [VOLBITS-1:0]         snap_vol_d   [NVOICES];
    logic [BITDEPTH-1:0]        mix_out_q, mix_out_d;
    logic                       mix_valid_q, mix_valid_d;
    logic                       overrun_q, overrun_d;

    logic signed [PRODW-1:0]    prod;
    logic signed [ACCW-1:0]     scaled;
    logic signed [ACCW-1:0]     sat_max;
    logic signed [ACCW-1:0]     sat_min;
    logic [BITDEPTH-1:0]        sat_val;

    // Shared MAC datapath, floor scaling and output saturation.
    always_comb begin
        prod    = PRODW'(snap_voice_q[idx_q]) * PRODW'($signed({1'b0, snap_vol_q[idx_q]}));
        scaled  = acc_q >>> VOLBITS;
        sat_max = '0;
        sat_max[BITDEPTH-2:0] = '1;
        sat_min = '1;
        sat_min[BITDEPTH-2:0] = '0;
        if (scaled > sat_max) begin
            sat_val = sat_max[BITDEPTH-1:0];
        end else if (scaled < sat_min) begin
            sat_val = sat_min[BITDEPTH-1:0];
        end else begin
            sat_val = scaled[BITDEPTH-1:0];
        end
    end

    // Next-state logic: IDLE -> ACCUM (one voice per cycle) -> FINISH -> IDLE.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        snap_voice_d = snap_voice_q;
        snap_vol_d   = snap_vol_q;
        mix_out_d    = mix_out_q;
        mix_valid_d  = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    for (int unsigned i = 0; i < NVOICES; i++) begin
                        snap_voice_d[i] = voices_in[i*BITDEPTH +: BITDEPTH];
                        snap_vol_d[i]   = volumes[i*VOLBITS +: VOLBITS];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACCW'(prod);
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NVOICES - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                mix_out_d   = sat_val;
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear first so a same-cycle overrun event takes priority.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (sample_strobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NVOICES; i++) begin
                snap_voice_q[i] <= '0;
                snap_vol_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mix_out_q    <= mix_out_d;
            mix_valid_q  <= mix_valid_d;
            overrun_q    <= overrun_d;
            snap_voice_q <= snap_voice_d;
            snap_vol_q   <= snap_vol_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (NVOICES=4, BITDEPTH=14, VOLBITS=8).
module tb_voice_mixer;

    localparam int NV = 4;
    localparam int BD = 14;
    localparam int VB = 8;

    logic              clk;
    logic              rst;
    logic              sample_strobe;
    logic [NV*BD-1:0]  voices_in;
    logic [NV*VB-1:0]  volumes;
    logic              overrun_clr;
    logic [BD-1:0]     mix_out;
    logic              mix_valid;
    logic              busy;
    logic              overrun;

    int errors;
    int checks;

    voice_mixer #(
        .NVOICES (NV),
        .BITDEPTH(BD),
        .VOLBITS (VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_strobe(sample_strobe),
        .voices_in    (voices_in),
        .volumes      (volumes),
        .overrun_clr  (overrun_clr),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input int v0, input int v1, input int v2, input int v3,
                              input int g0, input int g1, input int g2, input int g3);
        int v [NV];
        int g [NV];
        v = '{v0, v1, v2, v3};
        g = '{g0, g1, g2, g3};
        for (int i = 0; i < NV; i++) begin
            voices_in[i*BD +: BD] = BD'(v[i]);
            volumes[i*VB +: VB]   = VB'(g[i]);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NV; i++) begin
            voices_in[i*BD +: BD] = BD'($urandom);
            volumes[i*VB +: VB]   = VB'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe once, then follow the mix to its valid pulse with a cycle bound.
    task automatic do_mix(input string tag, input int expv, input bit scramble);
        int n;
        int busy_cnt;
        bit seen;
        seen = 1'b0;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check({tag, "_busy_after_strobe"}, int'(busy), 1);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            if (scramble) scramble_inputs();
            tick();
            n = k;
            if (mix_valid) begin
                seen = 1'b1;
                break;
            end
            busy_cnt += busy ? 1 : 0;
        end
        check({tag, "_valid_seen"}, int'(seen), 1);
        check({tag, "_latency"}, n, NV + 1);
        check({tag, "_busy_cycles"}, busy_cnt, NV + 1);
        check({tag, "_busy_at_valid"}, int'(busy), 0);
        check({tag, "_mix_out"}, $signed(mix_out), expv);
        tick();
        check({tag, "_valid_single"}, int'(mix_valid), 0);
    endtask

    initial begin
        int vcount;
        int bad;
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
        voices_in     = '0;
        volumes       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mix_out", $signed(mix_out), 0);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Main function and boundaries.
        set_inputs(1000, 0, 0, 0, 255, 0, 0, 0);
        do_mix("single", 996, 1'b0);
        set_inputs(0, -1001, 0, 0, 0, 128, 0, 0);
        do_mix("floor_neg", -501, 1'b0);
        set_inputs(0, -1000, 0, 0, 0, 128, 0, 0);
        do_mix("exact_neg", -500, 1'b0);
        set_inputs(8191, 8191, 8191, 8191, 255, 255, 255, 255);
        do_mix("sat_pos", 8191, 1'b0);
        set_inputs(-8192, -8192, -8192, -8192, 255, 255, 255, 255);
        do_mix("sat_neg", -8192, 1'b0);
        set_inputs(4000, 4000, 0, 0, 255, 255, 255, 255);
        do_mix("no_clip", 7968, 1'b0);
        check("no_overrun_yet", int'(overrun), 0);

        // Snapshot isolation: inputs change every cycle during the mix.
        set_inputs(1000, -2000, 3000, -4000, 10, 20, 30, 40);
        do_mix("isolation", -391, 1'b1);

        // Overrun: second strobe three cycles after the first is ignored.
        set_inputs(2000, 0, 0, 0, 128, 0, 0, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        tick();
        set_inputs(5000, 5000, 0, 0, 255, 255, 0, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            if (mix_valid) vcount++;
            tick();
        end
        check("ovr_valid_count", vcount, 1);
        check("ovr_mix_out", $signed(mix_out), 1000);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_busy_idle", int'(busy), 0);

        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear", int'(overrun), 0);

        // Strobe landing in FINISH is also an overrun.
        set_inputs(-256, 0, 0, 0, 255, 0, 0, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        repeat (NV) tick();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("fin_valid", int'(mix_valid), 1);
        check("fin_mix_out", $signed(mix_out), -255);
        check("fin_overrun", int'(overrun), 1);
        tick();
        check("fin_no_restart", int'(busy), 0);

        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear2", int'(overrun), 0);

        // Clear coinciding with an ignored strobe: the set wins.
        set_inputs(1000, 0, 0, 0, 255, 0, 0, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b1;
        overrun_clr   = 1'b1;
        tick();
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
        check("ovr_set_wins", int'(overrun), 1);
        repeat (8) tick();
        check("ovr_set_wins_mix", $signed(mix_out), 996);

        // Asynchronous reset in the middle of ACCUM aborts the mix.
        set_inputs(3000, 0, 0, 0, 255, 0, 0, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_mix_out", $signed(mix_out), 0);
        check("mid_rst_valid", int'(mix_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mix_valid || busy || overrun || (mix_out != '0)) bad++;
        end
        check("post_rst_quiet", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Time-multiplexed mixer that sits directly downstream of the per-voice synth chain (oscillator + AR envelope). On each sample strobe it snapshots NVOICES voice samples and per-voice volumes. It then accumulates volume-weighted sums with one shared multiplier, scales and saturates the result, and presents one BITDEPTH mixed sample with a valid pulse for the DAC/output stage.

## Interface
Parameters:
- NVOICES, 4: number of voices mixed (≥1)
- BITDEPTH, 14: sample width, in and out, signed two's complement
- VOLBITS, 8: per-voice volume width, unsigned; full scale = 2^VOLBITS−1

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sample_strobe  in  1  one-cycle pulse requesting a new mix
- voices_in  in  NVOICES*BITDEPTH  voice i at [i*BITDEPTH +: BITDEPTH], signed
- volumes  in  NVOICES*VOLBITS  volume i at [i*VOLBITS +: VOLBITS], unsigned
- overrun_clr  in  1  clears overrun
- mix_out  out  BITDEPTH  mixed sample, signed, held until next result
- mix_valid  out  1  one-cycle pulse when mix_out updates
- busy  out  1  high while a mix is in progress (state ≠ IDLE)
- overrun  out  1  sticky; strobe arrived while busy

## Operation
- State machine: IDLE → ACCUM → FINISH → IDLE.
- IDLE, sample_strobe=1:
  - Capture all voices_in and volumes into snapshot registers.
  - Clear the accumulator and set idx=0.
  - Go to ACCUM.
- IDLE, sample_strobe=0: hold.
- ACCUM, each cycle:
  - acc += snap_voice[idx] × {0, snap_vol[idx]}: signed × zero-extended unsigned.
  - Product width is BITDEPTH+VOLBITS+1.
  - idx++. On the cycle with idx==NVOICES−1, go to FINISH.
- Accumulator width: BITDEPTH+VOLBITS+clog2(NVOICES)+1. The accumulator never wraps.
- FINISH:
  - r = acc >>> VOLBITS: arithmetic shift, floor toward −∞.
  - Saturate r to [−2^(BITDEPTH−1), 2^(BITDEPTH−1)−1] and register it into mix_out.
  - Assert mix_valid for one cycle and go to IDLE.
- Snapshots isolate the mix from changes on voices_in/volumes after the strobe edge.
- Strobe while state ≠ IDLE, including in FINISH: ignored, no restart, overrun←1.
- overrun_clr=1 clears overrun. If a new overrun event occurs in the same cycle, set wins and overrun stays 1.
- mix_out is unchanged except in FINISH.

## Timing
- Reset (rst=0, async) forces these to zero and state to IDLE:
  - mix_out, mix_valid, busy, overrun
  - acc, idx, snapshots
- Reset mid-ACCUM/FINISH aborts the mix; no mix_valid is produced. After rst deasserts, the block waits in IDLE for the next strobe.
- Let E0 be the edge sampling sample_strobe=1 in IDLE.
  - busy=1 after E0.
  - MACs occur on E1..E_NVOICES.
  - mix_out/mix_valid are updated on E_(NVOICES+1).
  - busy=0 and mix_valid=1 during the same cycle after E_(NVOICES+1).
  - Latency is NVOICES+1 edges from the strobe edge to mix_valid (5 for NVOICES=4).
- The strobe period must be ≥ NVOICES+2 clk cycles; a shorter period sets overrun.
- mix_valid is never high for two consecutive cycles.

## Test plan
- Reset: drive rst=0 mid-activity → mix_out=0, mix_valid=0, busy=0, overrun=0. Release rst and hold strobe low → all outputs stay 0.
- Single voice (NVOICES=4): voice0=1000, vol0=255, other vols=0, strobe → mix_out=996. mix_valid pulses exactly 5 edges after the strobe edge, and busy is high for 5 cycles.
- Negative/floor: voice1=−1001, vol1=128, others vol 0 → mix_out=−501. With voice1=−1000 → −500.
- Saturation:
  - All voices=8191, vols=255 → mix_out=8191.
  - All voices=−8192, vols=255 → mix_out=−8192.
  - Voices {4000, 4000, 0, 0}, vols 255 → 7968 (no clip).
- Overrun: strobes at cycles 0 and 3 → only one mix_valid, result from the cycle-0 snapshot, overrun=1. overrun_clr alone → 0. overrun_clr coinciding with an ignored strobe → stays 1.
- Snapshot isolation: change voices_in/volumes every cycle during ACCUM → mix_out matches the values captured at the strobe edge.
